// File: rtl/alu_issue_stage.sv
// Registered RV32I decode/issue stage feeding the combinational ALU (OP, OP-IMM, LUI, AUIPC).
// Optional operand forwarding is enabled by defining ALU_ISSUE_FORWARD_EN.

`ifndef ALU_OPERATOR_ADD
`define ALU_OPERATOR_ADD  4'd0
`define ALU_OPERATOR_SUB  4'd1
`define ALU_OPERATOR_SLL  4'd2
`define ALU_OPERATOR_SLT  4'd3
`define ALU_OPERATOR_SLTU 4'd4
`define ALU_OPERATOR_XOR  4'd5
`define ALU_OPERATOR_SRL  4'd6
`define ALU_OPERATOR_SRA  4'd7
`define ALU_OPERATOR_OR   4'd8
`endif

module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
`ifdef ALU_ISSUE_FORWARD_EN
    input  logic               fwd_we,
    input  logic [RADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]    fwd_data,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_operator,
    output logic [XLEN-1:0]    alu_operand1,
    output logic [XLEN-1:0]    alu_operand2,
    output logic [RADDR_W-1:0] rd_addr,
    output logic               rd_we,
    output logic               illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt_r;
    logic [XLEN-1:0] shamt_i;
    logic [3:0]      op_c;
    logic [XLEN-1:0] op1_c;
    logic [XLEN-1:0] op2_c;
    logic            legal_c;
    logic            vld_p1;
    logic            accept;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u   = {in_instr[31:12], 12'b0};
    assign shamt_i = {{(XLEN-5){1'b0}}, in_instr[24:20]};

`ifdef ALU_ISSUE_FORWARD_EN
    // Forwarded data overrides the regfile read when it targets the same non-zero register.
    assign src1 = (fwd_we && (fwd_rd != '0) && (fwd_rd == in_instr[19:15])) ? fwd_data : rs1_data;
    assign src2 = (fwd_we && (fwd_rd != '0) && (fwd_rd == in_instr[24:20])) ? fwd_data : rs2_data;
`else
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif
    assign shamt_r = {{(XLEN-5){1'b0}}, src2[4:0]};

    always_comb begin
        op_c    = `ALU_OPERATOR_ADD;
        op1_c   = '0;
        op2_c   = '0;
        legal_c = 1'b0;
        case (opcode)
            OPC_OP: begin
                op1_c   = src1;
                op2_c   = src2;
                legal_c = (funct7 == F7_ZERO);
                case (funct3)
                    3'b000: begin
                        op_c    = (funct7 == F7_ALT) ? `ALU_OPERATOR_SUB : `ALU_OPERATOR_ADD;
                        legal_c = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b001: begin
                        op_c  = `ALU_OPERATOR_SLL;
                        op2_c = shamt_r;
                    end
                    3'b010: op_c = `ALU_OPERATOR_SLT;
                    3'b011: op_c = `ALU_OPERATOR_SLTU;
                    3'b100: op_c = `ALU_OPERATOR_XOR;
                    3'b101: begin
                        op_c    = (funct7 == F7_ALT) ? `ALU_OPERATOR_SRA : `ALU_OPERATOR_SRL;
                        op2_c   = shamt_r;
                        legal_c = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b110: op_c = `ALU_OPERATOR_OR;
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                op1_c   = src1;
                op2_c   = imm_i;
                legal_c = 1'b1;
                case (funct3)
                    3'b000: op_c = `ALU_OPERATOR_ADD;
                    3'b001: begin
                        op_c    = `ALU_OPERATOR_SLL;
                        op2_c   = shamt_i;
                        legal_c = (funct7 == F7_ZERO);
                    end
                    3'b010: op_c = `ALU_OPERATOR_SLT;
                    3'b011: op_c = `ALU_OPERATOR_SLTU;
                    3'b100: op_c = `ALU_OPERATOR_XOR;
                    3'b101: begin
                        op_c    = (funct7 == F7_ALT) ? `ALU_OPERATOR_SRA : `ALU_OPERATOR_SRL;
                        op2_c   = shamt_i;
                        legal_c = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b110: op_c = `ALU_OPERATOR_OR;
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_LUI: begin
                op2_c   = imm_u;
                legal_c = 1'b1;
            end
            OPC_AUIPC: begin
                op1_c   = in_pc;
                op2_c   = imm_u;
                legal_c = 1'b1;
            end
            default: legal_c = 1'b0;
        endcase
        // Illegal instructions still issue, but as a harmless ADD of zeros.
        if (!legal_c) begin
            op_c  = `ALU_OPERATOR_ADD;
            op1_c = '0;
            op2_c = '0;
        end
    end

    assign in_ready  = !vld_p1 || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p1;

    // Issue register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            illegal      <= 1'b0;
            rd_we        <= 1'b0;
            rd_addr      <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_operator <= `ALU_OPERATOR_ADD;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1       <= 1'b1;
            illegal      <= !legal_c;
            rd_we        <= legal_c && (in_instr[11:7] != 5'd0);
            rd_addr      <= in_instr[11:7];
            alu_operand1 <= op1_c;
            alu_operand2 <= op2_c;
            alu_operator <= op_c;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage; define ALU_ISSUE_FORWARD_EN to also cover forwarding.

`ifndef ALU_OPERATOR_ADD
`define ALU_OPERATOR_ADD  4'd0
`define ALU_OPERATOR_SUB  4'd1
`define ALU_OPERATOR_SLL  4'd2
`define ALU_OPERATOR_SLT  4'd3
`define ALU_OPERATOR_SLTU 4'd4
`define ALU_OPERATOR_XOR  4'd5
`define ALU_OPERATOR_SRL  4'd6
`define ALU_OPERATOR_SRA  4'd7
`define ALU_OPERATOR_OR   4'd8
`endif

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_operator;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
`ifdef ALU_ISSUE_FORWARD_EN
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
`ifdef ALU_ISSUE_FORWARD_EN
        .fwd_we       (fwd_we),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_operator (alu_operator),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .rd_addr      (rd_addr),
        .rd_we        (rd_we),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
`ifdef ALU_ISSUE_FORWARD_EN
        fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_op1",       alu_operand1,       32'd0);
        check("rst_op2",       alu_operand2,       32'd0);
        check("rst_operator",  {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_ADD});
        check("rst_rd_we",     {31'b0, rd_we},     32'd0);
        check("rst_illegal",   {31'b0, illegal},   32'd0);
        check("rst_rd_addr",   {27'b0, rd_addr},   32'd0);

        // ADDI x5,x1,-1
        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0);
        step();
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_op",    {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_ADD});
        check("addi_op1",   alu_operand1, 32'h10);
        check("addi_op2",   alu_operand2, 32'hFFFFFFFF);
        check("addi_rd",    {27'b0, rd_addr}, 32'd5);
        check("addi_we",    {31'b0, rd_we}, 32'd1);

        // SRA x3,x1,x2
        issue(32'h4020D1B3, 32'h0, 32'h80000000, 32'h123);
        step();
        check("sra_op",  {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_SRA});
        check("sra_op1", alu_operand1, 32'h80000000);
        check("sra_op2", alu_operand2, 32'h3);

        // SUB x3,x1,x2
        issue(32'h402081B3, 32'h0, 32'h9, 32'h4);
        step();
        check("sub_op",  {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_SUB});
        check("sub_op2", alu_operand2, 32'h4);

        // SRLI x5,x1,3
        issue(32'h0030D293, 32'h0, 32'h55, 32'h0);
        step();
        check("srli_op",  {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_SRL});
        check("srli_op2", alu_operand2, 32'h3);

        // LUI x6,0xABCDE
        issue(32'hABCDE337, 32'h0, 32'hDEAD, 32'h0);
        step();
        check("lui_op1", alu_operand1, 32'h0);
        check("lui_op2", alu_operand2, 32'hABCDE000);
        check("lui_rd",  {27'b0, rd_addr}, 32'd6);

        // AUIPC x7,0x12345
        issue(32'h12345397, 32'h100, 32'h0, 32'h0);
        step();
        check("auipc_op1", alu_operand1, 32'h100);
        check("auipc_op2", alu_operand2, 32'h12345000);
        check("auipc_op",  {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_ADD});

        // ANDI x5,x1,3 is not an ALU op here
        issue(32'h0030F293, 32'h0, 32'h77, 32'h0);
        step();
        check("andi_valid",   {31'b0, out_valid}, 32'd1);
        check("andi_illegal", {31'b0, illegal}, 32'd1);
        check("andi_we",      {31'b0, rd_we}, 32'd0);
        check("andi_op1",     alu_operand1, 32'h0);
        check("andi_op2",     alu_operand2, 32'h0);

        // SLLI with imm[11:5]=1
        issue(32'h02409293, 32'h0, 32'h1, 32'h0);
        step();
        check("slli_bad_illegal", {31'b0, illegal}, 32'd1);

        // ADDI x0,x1,1: legal but no writeback
        issue(32'h00108013, 32'h0, 32'h1, 32'h0);
        step();
        check("x0_illegal", {31'b0, illegal}, 32'd0);
        check("x0_we",      {31'b0, rd_we}, 32'd0);
        check("x0_op2",     alu_operand2, 32'h1);

        in_valid = 1'b0;
        step();
        check("idle_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: hold ADD for 3 cycles, then drain + accept SUB together
        out_ready = 1'b0;
        issue(32'h00208233, 32'h0, 32'h1, 32'h2);
        step();
        check("stall_acc_valid", {31'b0, out_valid}, 32'd1);
        issue(32'h402081B3, 32'h0, 32'h7, 32'h8);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_op1",      alu_operand1, 32'h1);
            check("stall_op",       {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_ADD});
            check("stall_valid",    {31'b0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_op1",   alu_operand1, 32'h7);
        check("b2b_op",    {28'b0, alu_operator}, {28'b0, `ALU_OPERATOR_SUB});
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // Flush drops incoming instruction
        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0);
        flush = 1'b1;
        step();
        check("flush_in_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;

        // Flush kills a held command
        out_ready = 1'b0;
        issue(32'h00208233, 32'h0, 32'h3, 32'h4);
        step();
        check("held_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        check("flush_held", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;

        // Async reset mid-stall
        issue(32'h00208233, 32'h0, 32'h5, 32'h6);
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #2;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_op1",   alu_operand1, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

`ifdef ALU_ISSUE_FORWARD_EN
        fwd_we = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hAA;
        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0);
        step();
        check("fwd_op1", alu_operand1, 32'hAA);
        // AUIPC ignores forwarding
        issue(32'h12345397, 32'h100, 32'h0, 32'h0);
        step();
        check("fwd_auipc_op1", alu_operand1, 32'h100);
        fwd_we = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
